issue_ctrl: RTL and testbench
=============================

// Module: issue_ctrl
// PURPOSE
//  Sequences the decode->execute handoff. Keeps a per-register scoreboard of in-flight writers.
//  Decides each cycle whether the decoded instruction issues, stalls fetch/decode, or is squashed.
//  Serialises access to the single shared multi-cycle mul/div unit.
//  Sits beside the decode stage; consumes decoded rs1/rs2/dst/ctl, drives pipeline-register enables.
// PARAMETERS
//  NREG        32  number of architectural integer registers (index width = $clog2(NREG))
//  PERF_W      32  width of performance counters (only with ISSUE_PERF_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  dec_valid    in   1   decode stage holds a valid instruction
//  dec_rs1      in   5   source register 1 index
//  dec_rs2      in   5   source register 2 index
//  dec_use_rs1  in   1   instruction reads rs1
//  dec_use_rs2  in   1   instruction reads rs2
//  dec_dst      in   5   destination register index
//  dec_wen      in   1   instruction writes dec_dst
//  dec_md       in   1   instruction needs the mul/div unit
//  ex_ready     in   1   execute stage can accept an instruction this cycle
//  wb_valid     in   1   writeback commits a register this cycle
//  wb_dst       in   5   register committed by writeback
//  md_done      in   1   mul/div unit finished (one-cycle pulse)
//  redirect     in   1   branch/jump redirect; kill the decode-stage instruction
//  issue        out  1   decode instruction moves to execute this cycle
//  stall_fd     out  1   hold fetch PC and F/D pipeline register
//  bubble_e     out  1   insert NOP into D/E register
//  md_busy      out  1   mul/div unit owned by an in-flight instruction
// BEHAVIOUR
//  Reset (reset==0, async): scoreboard all clear, md_busy=0; issue=0, stall_fd=0, bubble_e=1.
//  Scoreboard: busy[NREG-1:0], registered; busy[0] is hardwired 0, and writes to x0 are never tracked.
//  Hazard (combinational, same cycle):
//    raw = (use_rs1 & busy_eff[rs1]) | (use_rs2 & busy_eff[rs2])
//    busy_eff = busy with the wb_dst bit cleared when wb_valid (writeback-cycle bypass; regfile writes through).
//    waw = dec_wen & busy_eff[dec_dst]; stalls so that a single pending writer per register holds.
//    mdh = dec_md & md_busy & ~md_done.
//  issue    = dec_valid & ~redirect & ex_ready & ~raw & ~waw & ~mdh.
//  stall_fd = dec_valid & ~redirect & ~issue.
//  bubble_e = ~issue.
//  redirect takes priority: the decode instruction is dropped; stall_fd=0; scoreboard is untouched,
//    because older instructions already issued still write back.
//  Scoreboard update at posedge:
//    wb_valid clears busy[wb_dst]; issue & dec_wen & dst!=0 sets busy[dec_dst].
//    Same register set and cleared in the same cycle: set wins.
//  md_busy: set on issue & dec_md; cleared on md_done; if both occur in the same cycle, md_busy stays 1.
//  Anomalies:
//    md_done with md_busy=0 is ignored.
//    wb_valid to a non-busy register is ignored; no error state.
//  Latency: zero-cycle issue decision; a cleared hazard issues on the same cycle as its writeback.
// CONFIGURATION
//  ISSUE_PERF_EN defined: adds outputs perf_raw_stall, perf_md_stall, perf_issued [PERF_W-1:0].
//    Each counter increments once per cycle on its cause; raw has priority over md when both hold.
//    Counters saturate at all-ones and reset to 0.
//  ISSUE_PERF_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Package pipes: typedef issue_ctl_t {issue, stall_fd, bubble_e}; localparam NREG; creg_addr_t is reused.
//  Sub-module reg_scoreboard: the busy vector, set/clear ports and two combinational read ports with the wb bypass.
//    The hazard logic, md ownership and perf counters stay in issue_ctrl.
// TESTING
//  1 Reset mid-run with busy[5]=1, md_busy=1 -> next cycle: busy all 0, md_busy=0, bubble_e=1.
//  2 Issue x5<=...; next cycle dec rs1=5 -> stall_fd=1, issue=0 until wb_valid,wb_dst=5; on that cycle issue=1.
//  3 Writer to x0, then reader of x0 -> no stall; busy[0] stays 0.
//  4 Issue mul (dec_md); next dec_md -> stalls while md_busy; on the md_done cycle, issue=1 and md_busy stays 1.
//  5 RAW stall active, redirect=1 -> issue=0, stall_fd=0, bubble_e=1; busy vector unchanged.
//  6 wb_valid,wb_dst=7 and issue with dst=7 in the same cycle -> busy[7]=1 afterwards.
//    With ISSUE_PERF_EN: 3 RAW stall cycles -> perf_raw_stall=3.

Source files
------------

// File: rtl/pipes.sv
// Shared pipeline types for the decode/issue slice.
// Holds register-index types, the issue control bundle and a mask helper.
package pipes;

    localparam int NREG  = 32;
    localparam int REG_W = $clog2(NREG);

    typedef logic [REG_W-1:0] creg_addr_t;

    typedef struct packed {
        logic issue;
        logic stall_fd;
        logic bubble_e;
    } issue_ctl_t;

    function automatic logic [NREG-1:0] reg_mask(input creg_addr_t a);
        reg_mask    = '0;
        reg_mask[a] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-writer scoreboard with writeback-cycle bypass.
// Ports: set/clr requests, two read ports (rd1/rd2), busy_eff view.
module reg_scoreboard
    import pipes::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_addr,
    input  logic [REG_W-1:0] rd1_addr,
    input  logic [REG_W-1:0] rd2_addr,
    output logic             rd1_busy,
    output logic             rd2_busy,
    output logic [NREG-1:0]  busy_eff
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] set_m;
    logic [NREG-1:0] clr_m;
    logic [NREG-1:0] busy_d;

    always_comb begin
        set_m    = set_en ? reg_mask(set_addr) : '0;
        clr_m    = clr_en ? reg_mask(clr_addr) : '0;
        // the committing register reads as free: regfile writes through
        busy_eff = busy_q & ~clr_m;
        rd1_busy = busy_eff[rd1_addr];
        rd2_busy = busy_eff[rd2_addr];
        // set after clear so a same-cycle set wins; x0 never tracked
        busy_d    = (busy_q & ~clr_m) | set_m;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

// File: rtl/issue_ctrl.sv
// Decode->execute issue control: RAW/WAW/mul-div hazards, stall/bubble.
// Optional perf counters enabled by the ISSUE_PERF_EN macro.
module issue_ctrl
    import pipes::*;
`ifdef ISSUE_PERF_EN
#(
    parameter int PERF_W = 32
)
`endif
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic [4:0]        dec_dst,
    input  logic              dec_wen,
    input  logic              dec_md,
    input  logic              ex_ready,
    input  logic              wb_valid,
    input  logic [4:0]        wb_dst,
    input  logic              md_done,
    input  logic              redirect,
    output logic              issue,
    output logic              stall_fd,
    output logic              bubble_e,
`ifdef ISSUE_PERF_EN
    output logic [PERF_W-1:0] perf_raw_stall,
    output logic [PERF_W-1:0] perf_md_stall,
    output logic [PERF_W-1:0] perf_issued,
`endif
    output logic              md_busy
);

    logic            rd1_busy;
    logic            rd2_busy;
    logic [NREG-1:0] busy_eff;
    logic            raw;
    logic            waw;
    logic            mdh;
    logic            live;
    logic            set_en;
    issue_ctl_t      ctl;

    reg_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_addr (dec_dst),
        .clr_en   (wb_valid),
        .clr_addr (wb_dst),
        .rd1_addr (dec_rs1),
        .rd2_addr (dec_rs2),
        .rd1_busy (rd1_busy),
        .rd2_busy (rd2_busy),
        .busy_eff (busy_eff)
    );

    always_comb begin
        raw  = (dec_use_rs1 & rd1_busy) | (dec_use_rs2 & rd2_busy);
        waw  = dec_wen & busy_eff[dec_dst];
        mdh  = dec_md & md_busy & ~md_done;
        // outputs held at their idle values while in reset
        live = reset & dec_valid & ~redirect;
        ctl.issue    = live & ex_ready & ~raw & ~waw & ~mdh;
        ctl.stall_fd = live & ~ctl.issue;
        ctl.bubble_e = ~ctl.issue;
        set_en = ctl.issue & dec_wen & (dec_dst != '0);
    end

    assign issue    = ctl.issue;
    assign stall_fd = ctl.stall_fd;
    assign bubble_e = ctl.bubble_e;

    // a new owner may claim the unit in the same cycle the old one finishes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) md_busy <= 1'b0;
        else        md_busy <= (ctl.issue & dec_md) | (md_busy & ~md_done);
    end

`ifdef ISSUE_PERF_EN
    logic raw_cause;
    logic md_cause;

    assign raw_cause = live & raw;
    assign md_cause  = live & ~raw & mdh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_raw_stall <= '0;
            perf_md_stall  <= '0;
            perf_issued    <= '0;
        end else begin
            if (raw_cause && perf_raw_stall != '1)
                perf_raw_stall <= perf_raw_stall + 1'b1;
            if (md_cause && perf_md_stall != '1)
                perf_md_stall <= perf_md_stall + 1'b1;
            if (ctl.issue && perf_issued != '1)
                perf_issued <= perf_issued + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the issue rules.
module tb_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       dec_use_rs1;
    logic       dec_use_rs2;
    logic [4:0] dec_dst;
    logic       dec_wen;
    logic       dec_md;
    logic       ex_ready;
    logic       wb_valid;
    logic [4:0] wb_dst;
    logic       md_done;
    logic       redirect;
    logic       issue;
    logic       stall_fd;
    logic       bubble_e;
    logic       md_busy;
`ifdef ISSUE_PERF_EN
    logic [31:0] perf_raw_stall;
    logic [31:0] perf_md_stall;
    logic [31:0] perf_issued;
`endif

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .dec_dst     (dec_dst),
        .dec_wen     (dec_wen),
        .dec_md      (dec_md),
        .ex_ready    (ex_ready),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .md_done     (md_done),
        .redirect    (redirect),
        .issue       (issue),
        .stall_fd    (stall_fd),
        .bubble_e    (bubble_e),
`ifdef ISSUE_PERF_EN
        .perf_raw_stall (perf_raw_stall),
        .perf_md_stall  (perf_md_stall),
        .perf_issued    (perf_issued),
`endif
        .md_busy     (md_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit     m_busy[32];
    bit     m_md;
    longint m_raw;
    longint m_mds;
    longint m_iss;

    function automatic longint sat_inc(input longint v);
        return (v == 64'hFFFF_FFFF) ? v : v + 1;
    endfunction

    always @(negedge clk) begin
        bit          eff[32];
        bit          e_raw, e_waw, e_mdh, e_live, e_iss;
        logic [31:0] packed_busy;
        if (!reset) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_md  = 1'b0;
            m_raw = 0;
            m_mds = 0;
            m_iss = 0;
            chk("rst_issue", issue, 1'b0);
            chk("rst_stall", stall_fd, 1'b0);
            chk("rst_bubble", bubble_e, 1'b1);
            chk("rst_busy", dut.u_sb.busy_q, 32'h0);
            chk("rst_md", md_busy, 1'b0);
        end else begin
            eff = m_busy;
            if (wb_valid) eff[wb_dst] = 1'b0;
            e_raw  = (dec_use_rs1 && eff[dec_rs1]) ||
                     (dec_use_rs2 && eff[dec_rs2]);
            e_waw  = dec_wen && eff[dec_dst];
            e_mdh  = dec_md && m_md && !md_done;
            e_live = dec_valid && !redirect;
            e_iss  = e_live && ex_ready && !e_raw && !e_waw && !e_mdh;
            for (int i = 0; i < 32; i++) packed_busy[i] = m_busy[i];
            chk("issue", issue, e_iss);
            chk("stall_fd", stall_fd, e_live && !e_iss);
            chk("bubble_e", bubble_e, !e_iss);
            chk("md_busy", md_busy, m_md);
            chk("busy_vec", dut.u_sb.busy_q, packed_busy);
`ifdef ISSUE_PERF_EN
            chk("perf_raw", perf_raw_stall, m_raw);
            chk("perf_md", perf_md_stall, m_mds);
            chk("perf_iss", perf_issued, m_iss);
            if (e_live && e_raw) m_raw = sat_inc(m_raw);
            else if (e_live && e_mdh) m_mds = sat_inc(m_mds);
            if (e_iss) m_iss = sat_inc(m_iss);
`endif
            if (wb_valid) m_busy[wb_dst] = 1'b0;
            if (e_iss && dec_wen && dec_dst != 0) m_busy[dec_dst] = 1'b1;
            if (md_done) m_md = 1'b0;
            if (e_iss && dec_md) m_md = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        dec_valid   = 1'b0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_dst     = '0;
        dec_wen     = 1'b0;
        dec_md      = 1'b0;
        ex_ready    = 1'b1;
        wb_valid    = 1'b0;
        wb_dst      = '0;
        md_done     = 1'b0;
        redirect    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

`ifdef ISSUE_PERF_EN
    logic [31:0] base;
`endif

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // writer to x5, then dependent reader stalls until writeback
        cyc(); idle(); dec_valid = 1; dec_wen = 1; dec_dst = 5;
        @(negedge clk); chk("t2_wr_issue", issue, 1'b1);
        cyc(); idle(); dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5;
        @(negedge clk); chk("t2_stall", stall_fd, 1'b1);
        chk("t2_noissue", issue, 1'b0);
        cyc();
        @(negedge clk); chk("t2_stall2", stall_fd, 1'b1);
        // redirect over an active RAW stall
        cyc(); redirect = 1;
        @(negedge clk); chk("t5_issue", issue, 1'b0);
        chk("t5_stall", stall_fd, 1'b0);
        chk("t5_bubble", bubble_e, 1'b1);
        cyc(); redirect = 0;
        @(negedge clk); chk("t5_busy5", dut.u_sb.busy_q[5], 1'b1);
        cyc(); wb_valid = 1; wb_dst = 5;
        @(negedge clk); chk("t2_wb_issue", issue, 1'b1);
        cyc(); idle();
        @(negedge clk); chk("t2_busy5_clr", dut.u_sb.busy_q[5], 1'b0);

        // x0 writer never tracked
        cyc(); idle(); dec_valid = 1; dec_wen = 1; dec_dst = 0;
        @(negedge clk); chk("t3_wr0", issue, 1'b1);
        cyc(); idle(); dec_valid = 1; dec_use_rs1 = 1; dec_use_rs2 = 1;
        @(negedge clk); chk("t3_rd0", issue, 1'b1);
        chk("t3_busy0", dut.u_sb.busy_q[0], 1'b0);

        // mul/div serialisation
        cyc(); idle(); dec_valid = 1; dec_md = 1;
        @(negedge clk); chk("t4_md1", issue, 1'b1);
        cyc();
        @(negedge clk); chk("t4_mdbusy", md_busy, 1'b1);
        chk("t4_stall", stall_fd, 1'b1);
        cyc(); md_done = 1;
        @(negedge clk); chk("t4_done_issue", issue, 1'b1);
        cyc(); idle();
        @(negedge clk); chk("t4_md_stays", md_busy, 1'b1);
        cyc(); md_done = 1;
        cyc(); idle();
        @(negedge clk); chk("t4_md_free", md_busy, 1'b0);

        // same-cycle set and clear of x7
        cyc(); idle(); dec_valid = 1; dec_wen = 1; dec_dst = 7;
        @(negedge clk); chk("t6_wr7", issue, 1'b1);
        cyc(); wb_valid = 1; wb_dst = 7;
        @(negedge clk); chk("t6_wr7_again", issue, 1'b1);
        cyc(); idle();
        @(negedge clk); chk("t6_busy7", dut.u_sb.busy_q[7], 1'b1);

`ifdef ISSUE_PERF_EN
        base = perf_raw_stall;
        cyc(); idle(); dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = 7;
        cyc();
        cyc();
        cyc(); idle(); wb_valid = 1; wb_dst = 7;
        @(negedge clk); chk("perf_raw3", perf_raw_stall - base, 32'd3);
`else
        cyc(); idle(); wb_valid = 1; wb_dst = 7;
`endif

        // reset mid-run with state held
        cyc(); idle(); dec_valid = 1; dec_wen = 1; dec_dst = 5; dec_md = 1;
        cyc(); idle();
        @(negedge clk); chk("t1_pre_b5", dut.u_sb.busy_q[5], 1'b1);
        chk("t1_pre_md", md_busy, 1'b1);
        cyc(); reset = 0; dec_valid = 1;
        @(negedge clk); chk("t1_busy", dut.u_sb.busy_q, 32'h0);
        chk("t1_md", md_busy, 1'b0);
        chk("t1_bubble", bubble_e, 1'b1);
        chk("t1_issue", issue, 1'b0);
        cyc(); reset = 1; idle();
`ifdef ISSUE_PERF_EN
        @(negedge clk); chk("t1_perf", perf_issued, 32'd0);
`endif

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset       = ($urandom_range(399) != 0);
            dec_valid   = ($urandom_range(9) < 8);
            dec_rs1     = 5'($urandom_range(7));
            dec_rs2     = 5'($urandom_range(7));
            dec_use_rs1 = $urandom_range(1) == 1;
            dec_use_rs2 = $urandom_range(1) == 1;
            dec_dst     = 5'($urandom_range(7));
            dec_wen     = ($urandom_range(3) != 0);
            dec_md      = ($urandom_range(3) == 0);
            ex_ready    = ($urandom_range(9) < 8);
            wb_valid    = ($urandom_range(9) < 5);
            wb_dst      = 5'($urandom_range(7));
            md_done     = ($urandom_range(9) < 3);
            redirect    = ($urandom_range(9) == 0);
        end
        cyc(); reset = 1; idle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
